// File: rtl/npc_bus_pkg.sv
// Shared memory-bus definitions: arbiter FSM encoding, master IDs, default widths.
package npc_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    MID_IFU = 1'b0,
    MID_LSU = 1'b1
  } mid_t;

endpackage

// File: rtl/npc_mem_arbiter_tff.sv
// Toggle flop with parameterised reset value; holds the round-robin pointer.
// One cycle from t to q; no handshake.
module tff #(
  parameter bit RST_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)    q <= RST_VALUE;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Two-master round-robin arbiter onto one memory slave, one transaction in flight.
// Response reaches the master one cycle after s_resp_valid; requests wait in ISSUE until s_req_ready.
module npc_mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_resp_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_resp_err,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  input  logic [DATA_W-1:0]   s_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t            state, state_nxt;
  mid_t              grant, grant_nxt;
  logic              prio;
  logic [CNT_W-1:0]  cnt;
  logic              accept, timeout_hit, done;
  logic              resp_vld_q, resp_err_q;
  mid_t              resp_mid_q;
  logic [DATA_W-1:0] rdata_q;

  assign accept      = (state == ISSUE) && s_req_ready;
  // A response arriving on the limit cycle takes precedence over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (state == RESP) && !s_resp_valid && (cnt == CNT_W'(LIMIT));
  assign done        = (state == RESP) && (s_resp_valid || timeout_hit);

  tff #(.RST_VALUE(0)) u_prio (
    .clk (clk),
    .rst (rst),
    .t   (done && (grant == mid_t'(prio))),
    .q   (prio)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m0_req_valid || m1_req_valid) state_nxt = ISSUE;
      ISSUE:   if (s_req_ready) state_nxt = RESP;
      RESP:    if (s_resp_valid) state_nxt = IDLE;
               else if (timeout_hit) state_nxt = DRAIN;
      DRAIN:   if (s_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_req_valid  = 1'b0;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    if (state == ISSUE) begin
      s_req_valid  = 1'b1;
      m0_req_ready = (grant == MID_IFU) && s_req_ready;
      m1_req_ready = (grant == MID_LSU) && s_req_ready;
    end
  end

  always_comb begin
    grant_nxt = MID_IFU;
    if (m0_req_valid && m1_req_valid) grant_nxt = mid_t'(prio);
    else if (m1_req_valid)            grant_nxt = MID_LSU;
  end

  assign s_addr  = (grant == MID_LSU) ? m1_addr  : m0_addr;
  assign s_wen   = (grant == MID_LSU) ? m1_wen   : m0_wen;
  assign s_wdata = (grant == MID_LSU) ? m1_wdata : m0_wdata;
  assign s_wmask = (grant == MID_LSU) ? m1_wmask : m0_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= MID_IFU;
      cnt        <= '0;
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_mid_q <= MID_IFU;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE) grant <= grant_nxt;
      if (accept)              cnt <= '0;
      else if (state == RESP)  cnt <= cnt + CNT_W'(1);
      resp_vld_q <= done;
      if (done) begin
        resp_mid_q <= grant;
        resp_err_q <= !s_resp_valid;
        rdata_q    <= s_resp_valid ? s_rdata : '0;
      end
    end
  end

  assign m0_resp_valid = resp_vld_q && (resp_mid_q == MID_IFU);
  assign m1_resp_valid = resp_vld_q && (resp_mid_q == MID_LSU);
  assign m0_resp_err   = m0_resp_valid && resp_err_q;
  assign m1_resp_err   = m1_resp_valid && resp_err_q;
  assign m0_rdata      = rdata_q;
  assign m1_rdata      = rdata_q;

endmodule
